// File: rtl/ar_sequencer_if.sv
// Instruction-memory fetch channel between ar_sequencer (master) and imem (slave).
// req is held until ack; data is valid in the cycle ack is high.
interface ar_sequencer_if #(
  parameter int PC_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [31:0]     data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );
endinterface

// File: rtl/ar_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the AR datapath.
// Optional performance counters are built only when AR_SEQ_PERF_EN is defined.
module ar_sequencer #(
  parameter int          PC_W      = 32,
  parameter int          PC_STEP   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]  AR_OPCODE = 5'b00000,
  parameter logic [4:0]  HALT_OP   = 5'b11111
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  ar_sequencer_if.master     imem,
  output logic [31:0]        instr,
  output logic               regWrite,
  output logic [PC_W-1:0]    pc,
  output logic               illegal,
  output logic               busy,
  output logic               halted,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] op;
  logic       pc_adv;
  logic       fetch_done;

  assign op         = instr[31:27];
  assign fetch_done = (state == FETCH) && imem.ack;

  // Halt is checked before AR so a HALT_OP equal to AR_OPCODE still halts.
  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    pc_adv    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (imem.ack) begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (op == HALT_OP) begin
          state_nxt = HALT;
        end else if (op == AR_OPCODE) begin
          state_nxt = EXECUTE;
        end else begin
          illegal   = 1'b1;
          pc_adv    = 1'b1;
          state_nxt = FETCH;
        end
      end
      EXECUTE: begin
        state_nxt = WRITEBACK;
      end
      WRITEBACK: begin
        pc_adv    = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc <= RESET_PC;
    end else if (pc_adv) begin
      pc <= pc + PC_W'(PC_STEP);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      instr <= '0;
    end else if (fetch_done) begin
      instr <= imem.data;
    end
  end

  // Moore strobes decoded from the state register only.
  assign imem.req  = (state == FETCH);
  assign imem.addr = pc;
  assign regWrite  = (state == WRITEBACK);
  assign halted    = (state == HALT);
  assign busy      = (state != IDLE) && (state != HALT);

`ifdef AR_SEQ_PERF_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (regWrite) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_ar_sequencer.sv
// Self-checking bench for ar_sequencer: cycle timelines derived from the per-state latency rules.
module tb_ar_sequencer;

  localparam logic [4:0]  OP_AR   = 5'b00000;
  localparam logic [4:0]  OP_HALT = 5'b11111;
  localparam logic [31:0] W_HALT  = 32'hF800_0000;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic start = 1'b0;
  logic start4 = 1'b0;

  always #5 CLK = ~CLK;

  ar_sequencer_if #(.PC_W(32)) imem ();
  ar_sequencer_if #(.PC_W(4))  imem4 ();

  logic [31:0] instr, cycle_cnt, instr_cnt, pc;
  logic        regWrite, illegal, busy, halted;
  logic [31:0] instr4, cycle_cnt4, instr_cnt4;
  logic [3:0]  pc4;
  logic        regWrite4, illegal4, busy4, halted4;

  ar_sequencer #(.PC_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .imem(imem),
    .instr(instr), .regWrite(regWrite), .pc(pc), .illegal(illegal),
    .busy(busy), .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  ar_sequencer #(.PC_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .start(start4), .imem(imem4),
    .instr(instr4), .regWrite(regWrite4), .pc(pc4), .illegal(illegal4),
    .busy(busy4), .halted(halted4), .cycle_cnt(cycle_cnt4), .instr_cnt(instr_cnt4)
  );

  // Memory model: word array plus a per-address wait-state count.
  logic [31:0] mem   [0:63];
  int          waits [0:63];
  int          wcnt;

  assign imem.data = mem[imem.addr[7:2]];
  assign imem.ack  = imem.req && (wcnt == waits[imem.addr[7:2]]);

  always @(posedge CLK or posedge RESET) begin
    if (RESET) wcnt <= 0;
    else if (imem.req && !imem.ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign imem4.data = 32'h0000_1234;
  assign imem4.ack  = imem4.req;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf(input int v);
`ifdef AR_SEQ_PERF_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        rw;
    logic        ill;
    logic        busy;
    logic        halt;
    logic [31:0] instr;
  } exp_t;

  exp_t tl[$];

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      mem[i]   = W_HALT;
      waits[i] = 0;
    end
  endtask

  task automatic push(input logic req, input logic [31:0] p, input logic rw, input logic ill,
                      input logic bsy, input logic hlt, input logic [31:0] ins);
    exp_t e;
    e.req = req; e.pc = p; e.rw = rw; e.ill = ill; e.busy = bsy; e.halt = hlt; e.instr = ins;
    tl.push_back(e);
  endtask

  // Expected per-cycle trace: fetch = waits+1 cycles, decode 1, AR adds execute and writeback.
  task automatic build(input int tail);
    logic [31:0] p, cur;
    logic [4:0]  o;
    int          i;
    p = 0;
    cur = 0;
    tl.delete();
    for (int n = 0; n < 64; n++) begin
      i = int'(p >> 2);
      for (int w = 0; w <= waits[i]; w++) push(1, p, 0, 0, 1, 0, cur);
      cur = mem[i];
      o = cur[31:27];
      if (o == OP_HALT) begin
        push(0, p, 0, 0, 1, 0, cur);
        for (int t = 0; t < tail; t++) push(0, p, 0, 0, 0, 1, cur);
        break;
      end else if (o == OP_AR) begin
        push(0, p, 0, 0, 1, 0, cur);
        push(0, p, 0, 0, 1, 0, cur);
        push(0, p, 1, 0, 1, 0, cur);
        p = p + 4;
      end else begin
        push(0, p, 0, 1, 1, 0, cur);
        p = p + 4;
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic run(input string name);
    int cc, ic;
    cc = 0;
    ic = 0;
    do_reset();
    start = 1'b1;
    foreach (tl[k]) begin
      @(negedge CLK);
      start = 1'($urandom_range(0, 1));
      chk({name, ".req"},     64'(imem.req),   64'(tl[k].req));
      chk({name, ".addr"},    64'(imem.addr),  64'(tl[k].pc));
      chk({name, ".regWrite"},64'(regWrite),   64'(tl[k].rw));
      chk({name, ".illegal"}, 64'(illegal),    64'(tl[k].ill));
      chk({name, ".busy"},    64'(busy),       64'(tl[k].busy));
      chk({name, ".halted"},  64'(halted),     64'(tl[k].halt));
      chk({name, ".pc"},      64'(pc),         64'(tl[k].pc));
      chk({name, ".instr"},   64'(instr),      64'(tl[k].instr));
      chk({name, ".cycle_cnt"}, 64'(cycle_cnt), 64'(perf(cc)));
      chk({name, ".instr_cnt"}, 64'(instr_cnt), 64'(perf(ic)));
      cc += int'(tl[k].busy);
      ic += int'(tl[k].rw);
    end
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    bit found;

    // Reset and idle with start low.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("idle.pc", 64'(pc), 64'd0);
      chk("idle.busy", 64'(busy), 64'd0);
      chk("idle.req", 64'(imem.req), 64'd0);
      chk("idle.regWrite", 64'(regWrite), 64'd0);
      chk("idle.halted", 64'(halted), 64'd0);
      chk("idle.instr", 64'(instr), 64'd0);
    end

    // Zero-wait AR then halt.
    clear_mem();
    mem[0] = 32'h0001_0820;
    build(3);
    run("zero_wait");

    // Three wait states on the first fetch.
    clear_mem();
    mem[0] = 32'h0002_1040;
    waits[0] = 3;
    build(3);
    run("wait3");

    // Illegal opcode then halt; random start during HALT must be ignored.
    clear_mem();
    mem[0] = 32'h2800_0000;
    build(8);
    run("ill_halt");

    // Randomized programs terminated by a halt word.
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 6)
          mem[i] = {OP_AR, 27'($urandom)};
        else
          mem[i] = {5'($urandom_range(1, 30)), 27'($urandom)};
        waits[i] = $urandom_range(0, 3);
      end
      waits[len] = $urandom_range(0, 3);
      build(4);
      run("random");
    end

    // Reset asserted mid-fetch while ack is still pending.
    clear_mem();
    mem[0] = 32'h4800_0000;
    mem[1] = 32'h0000_0001;
    waits[1] = 10;
    do_reset();
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (imem.req && imem.addr == 32'd4) found = 1'b1;
    end
    chk("midfetch.reached", 64'(found), 64'd1);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("midfetch.req", 64'(imem.req), 64'd0);
    chk("midfetch.busy", 64'(busy), 64'd0);
    chk("midfetch.pc", 64'(pc), 64'd0);
    chk("midfetch.instr", 64'(instr), 64'd0);
    chk("midfetch.cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("midfetch.instr_cnt", 64'(instr_cnt), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midfetch.idle_req", 64'(imem.req), 64'd0);

    // 4-bit PC wraps after four AR instructions.
    do_reset();
    start4 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      start4 = 1'b0;
      chk("wrap.regWrite", 64'(regWrite4), 64'(c % 4 == 0));
      chk("wrap.req", 64'(imem4.req), 64'(c % 4 == 1));
      chk("wrap.pc", 64'(pc4), 64'((4 * ((c - 1) / 4)) % 16));
      chk("wrap.cycle_cnt", 64'(cycle_cnt4), 64'(perf(c - 1)));
      chk("wrap.instr_cnt", 64'(instr_cnt4), 64'(perf((c - 1) / 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
